// File: rtl/adc_multi_read.sv
// ---------------------------------------------------------------------------
// adc_multi_read
//
// Reads a multi-channel serial ADC a programmable number of times (2^log2_n)
// and produces the per-channel average. Each conversion is triggered by a
// sample strobe; the frame is shifted in MSB first with channel NUM_CH-1
// first and channel 0 last. Results and per-channel overrange flags update
// together with a one-cycle complete pulse.
//
// Ports:
//   clk_i              system clock, everything on the rising edge
//   rst_i              synchronous active-high reset
//   start_cycle_conv_i async; rising edge starts an averaging cycle
//   sample_adc_i       async; rising edge triggers one conversion
//   log2_n_i           log2 of the sample count, latched at cycle start
//   abort_i            synchronous; abandons the current cycle
//   busy_o             high while a cycle is in progress
//   complete_o         one-cycle pulse when data_out_o/overrange_o update
//   timeout_err_o      one-cycle pulse when the ADC busy line never fell
//   data_out_o         averaged results, channel k at [k*OUT_WIDTH +: OUT_WIDTH]
//   overrange_o        per channel: a full-scale sample was seen last cycle
//   cnv_o              ADC convert strobe
//   adc_busy_i         async ADC busy
//   miso_i             serial data from the ADC
//   sck_o              serial clock to the ADC, idle low
// ---------------------------------------------------------------------------
module adc_multi_read #(
  parameter int NUM_CH       = 2,
  parameter int CH_WIDTH     = 18,
  parameter int OUT_WIDTH    = 24,
  parameter int MAX_LOG2_N   = 10,
  parameter int SCK_DIV      = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_cycle_conv_i,
  input  logic                        sample_adc_i,
  input  logic [3:0]                  log2_n_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        complete_o,
  output logic                        timeout_err_o,
  output logic [NUM_CH*OUT_WIDTH-1:0] data_out_o,
  output logic [NUM_CH-1:0]           overrange_o,
  output logic                        cnv_o,
  input  logic                        adc_busy_i,
  input  logic                        miso_i,
  output logic                        sck_o
);

  localparam int ACC_W     = CH_WIDTH + MAX_LOG2_N;
  localparam int FRAME_W   = NUM_CH * CH_WIDTH;
  localparam int DATA_W    = NUM_CH * OUT_WIDTH;
  localparam int BIT_CNT_W = $clog2(FRAME_W + 1);
  localparam int SMP_CNT_W = MAX_LOG2_N + 1;
  localparam int DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int WAIT_W    = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [BIT_CNT_W-1:0] FRAME_BITS = BIT_CNT_W'(FRAME_W);
  localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(SCK_DIV - 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST  = WAIT_W'(BUSY_TIMEOUT - 1);
  localparam logic [3:0]           NLOG_MAX   = 4'(MAX_LOG2_N);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    CONVERT,
    WAIT_ADC,
    SHIFT,
    ACCUM,
    CHECK,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             startSync_q, sampleSync_q, busySync_q;
  logic [3:0]             nLog_q, nLog_d;
  logic [ACC_W-1:0]       acc_q [NUM_CH];
  logic [ACC_W-1:0]       acc_d [NUM_CH];
  logic [NUM_CH-1:0]      ovrWork_q, ovrWork_d;
  logic [SMP_CNT_W-1:0]   sampleCnt_q, sampleCnt_d;
  logic [WAIT_W-1:0]      waitCnt_q, waitCnt_d;
  logic [DIV_W-1:0]       divCnt_q, divCnt_d;
  logic [BIT_CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic                   sck_q, sck_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [NUM_CH-1:0]      ovrOut_q, ovrOut_d;
  logic                   complete_q, complete_d;
  logic                   timeout_q, timeout_d;

  logic                   startRise, sampleRise, busyFall;
  logic [CH_WIDTH-1:0]    sample [NUM_CH];

  // Stage 0 holds the newest value of each asynchronous input, stage 1 the
  // one before it; edges are judged by comparing the two stages.
  assign startRise  = startSync_q[0]  & ~startSync_q[1];
  assign sampleRise = sampleSync_q[0] & ~sampleSync_q[1];
  assign busyFall   = ~busySync_q[0]  &  busySync_q[1];

  // Channel 0 arrives last, so it ends up in the least significant bits of
  // the shift register; channel NUM_CH-1 sits at the top.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sample[k] = shift_q[k*CH_WIDTH +: CH_WIDTH];
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign cnv_o         = (state_q == CONVERT);
  assign sck_o         = sck_q;
  assign complete_o    = complete_q;
  assign timeout_err_o = timeout_q;
  assign data_out_o    = data_q;
  assign overrange_o   = ovrOut_q;

  // State and datapath registers. Reset clears everything including the
  // synchronisers, so a partially collected cycle is simply lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      startSync_q  <= '0;
      sampleSync_q <= '0;
      busySync_q   <= '0;
      nLog_q       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc_q[k] <= '0;
      end
      ovrWork_q    <= '0;
      sampleCnt_q  <= '0;
      waitCnt_q    <= '0;
      divCnt_q     <= '0;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      sck_q        <= 1'b0;
      data_q       <= '0;
      ovrOut_q     <= '0;
      complete_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      startSync_q  <= {startSync_q[0], start_cycle_conv_i};
      sampleSync_q <= {sampleSync_q[0], sample_adc_i};
      busySync_q   <= {busySync_q[0], adc_busy_i};
      nLog_q       <= nLog_d;
      acc_q        <= acc_d;
      ovrWork_q    <= ovrWork_d;
      sampleCnt_q  <= sampleCnt_d;
      waitCnt_q    <= waitCnt_d;
      divCnt_q     <= divCnt_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      sck_q        <= sck_d;
      data_q       <= data_d;
      ovrOut_q     <= ovrOut_d;
      complete_q   <= complete_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state and datapath logic. The busy timer starts at 1 in CONVERT so
  // that a timeout becomes visible exactly BUSY_TIMEOUT cycles after cnv
  // rose. During SHIFT the divider toggles sck; miso is captured on the
  // cycle sck goes high, and the frame ends on the falling edge that
  // follows the last captured bit. Abort is applied last so it overrides
  // every state except IDLE, including a result update in DONE.
  always_comb begin
    state_d     = state_q;
    nLog_d      = nLog_q;
    acc_d       = acc_q;
    ovrWork_d   = ovrWork_q;
    sampleCnt_d = sampleCnt_q;
    waitCnt_d   = waitCnt_q;
    divCnt_d    = divCnt_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    sck_d       = sck_q;
    data_d      = data_q;
    ovrOut_d    = ovrOut_q;
    complete_d  = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        sck_d = 1'b0;
        if (startRise) begin
          nLog_d = (log2_n_i > NLOG_MAX) ? NLOG_MAX : log2_n_i;
          for (int k = 0; k < NUM_CH; k++) begin
            acc_d[k] = '0;
          end
          ovrWork_d   = '0;
          sampleCnt_d = '0;
          state_d     = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        waitCnt_d = '0;
        if (sampleRise) begin
          state_d = CONVERT;
        end
      end

      CONVERT: begin
        waitCnt_d = WAIT_W'(1);
        state_d   = WAIT_ADC;
      end

      WAIT_ADC: begin
        if (busyFall) begin
          divCnt_d = '0;
          bitCnt_d = '0;
          sck_d    = 1'b0;
          state_d  = SHIFT;
        end else if (waitCnt_q >= WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end

      SHIFT: begin
        if (divCnt_q == DIV_LAST) begin
          divCnt_d = '0;
          sck_d    = ~sck_q;
          if (!sck_q) begin
            shift_d  = FRAME_W'({shift_q, miso_i});
            bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
          end else if (bitCnt_q == FRAME_BITS) begin
            state_d = ACCUM;
          end
        end else begin
          divCnt_d = divCnt_q + DIV_W'(1);
        end
      end

      ACCUM: begin
        for (int k = 0; k < NUM_CH; k++) begin
          acc_d[k] = acc_q[k] + ACC_W'(sample[k]);
          if (&sample[k]) begin
            ovrWork_d[k] = 1'b1;
          end
        end
        sampleCnt_d = sampleCnt_q + SMP_CNT_W'(1);
        state_d     = CHECK;
      end

      CHECK: begin
        if (sampleCnt_q == (SMP_CNT_W'(1) << nLog_q)) begin
          state_d = DONE;
        end else begin
          state_d = WAIT_TICK;
        end
      end

      DONE: begin
        for (int k = 0; k < NUM_CH; k++) begin
          data_d[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(acc_q[k] >> nLog_q);
        end
        ovrOut_d   = ovrWork_q;
        complete_d = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d    = IDLE;
      sck_d      = 1'b0;
      complete_d = 1'b0;
      timeout_d  = 1'b0;
      data_d     = data_q;
      ovrOut_d   = ovrOut_q;
    end
  end

endmodule

// File: tb/tb_adc_multi_read.sv
// ---------------------------------------------------------------------------
// tb_adc_multi_read
//
// Self-checking bench for adc_multi_read. A behavioural ADC answers each cnv
// pulse with a frame taken from a queue; the stimulus side computes the
// expected averages from the raw samples and queues them, and a monitor
// compares them whenever complete_o pulses.
// ---------------------------------------------------------------------------
module tb_adc_multi_read;

  localparam int NUM_CH       = 2;
  localparam int CH_WIDTH     = 18;
  localparam int OUT_WIDTH    = 24;
  localparam int MAX_LOG2_N   = 7;
  localparam int SCK_DIV      = 2;
  localparam int BUSY_TIMEOUT = 255;
  localparam int FRAME_W      = NUM_CH * CH_WIDTH;
  localparam int DATA_W       = NUM_CH * OUT_WIDTH;
  localparam int CONV_WAIT    = 2 * FRAME_W * SCK_DIV + 20;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [NUM_CH-1:0] ovr;
  } result_t;

  logic                 clk;
  logic                 rst_i;
  logic                 start_cycle_conv_i;
  logic                 sample_adc_i;
  logic [3:0]           log2_n_i;
  logic                 abort_i;
  logic                 busy_o;
  logic                 complete_o;
  logic                 timeout_err_o;
  logic [DATA_W-1:0]    data_out_o;
  logic [NUM_CH-1:0]    overrange_o;
  logic                 cnv_o;
  logic                 adc_busy_i;
  logic                 miso_i;
  logic                 sck_o;

  int                   checks = 0;
  int                   failures = 0;
  int                   cnvCount = 0;
  int                   cnvRun = 0;
  int                   completeRun = 0;
  bit                   expectTimeout = 0;
  bit                   stuckBusy = 0;
  logic [DATA_W-1:0]    lastExpData = '0;
  logic [FRAME_W-1:0]   curFrame = '0;
  int                   bitPos = 0;
  result_t              expQ [$];
  logic [FRAME_W-1:0]   frameQ [$];
  logic [CH_WIDTH-1:0]  samp [0:127][0:NUM_CH-1];

  adc_multi_read #(
    .NUM_CH       (NUM_CH),
    .CH_WIDTH     (CH_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH),
    .MAX_LOG2_N   (MAX_LOG2_N),
    .SCK_DIV      (SCK_DIV),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .start_cycle_conv_i (start_cycle_conv_i),
    .sample_adc_i       (sample_adc_i),
    .log2_n_i           (log2_n_i),
    .abort_i            (abort_i),
    .busy_o             (busy_o),
    .complete_o         (complete_o),
    .timeout_err_o      (timeout_err_o),
    .data_out_o         (data_out_o),
    .overrange_o        (overrange_o),
    .cnv_o              (cnv_o),
    .adc_busy_i         (adc_busy_i),
    .miso_i             (miso_i),
    .sck_o              (sck_o)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runaway guard so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  // ADC model: after each convert strobe it goes busy for a few cycles,
  // then presents the MSB of the next queued frame and drops busy. When
  // stuckBusy is set it never releases busy.
  initial begin
    adc_busy_i = 1'b0;
    miso_i     = 1'b0;
    forever begin
      @(posedge cnv_o);
      #1 adc_busy_i = 1'b1;
      if (!stuckBusy) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        if (frameQ.size() > 0) curFrame = frameQ.pop_front();
        else curFrame = '0;
        bitPos     = FRAME_W - 1;
        miso_i     = curFrame[bitPos];
        adc_busy_i = 1'b0;
      end
    end
  end

  // ADC shifts the next bit out on every falling sck edge.
  always @(negedge sck_o) begin
    if (bitPos > 0) begin
      bitPos = bitPos - 1;
      miso_i = curFrame[bitPos];
    end
  end

  // Monitor: counts cnv pulses and checks their width, checks complete
  // against the scoreboard and flags any timeout nobody asked for.
  always @(negedge clk) begin
    result_t e;
    if (rst_i) begin
      cnvRun      = 0;
      completeRun = 0;
    end else begin
      if (cnv_o) begin
        if (cnvRun == 0) cnvCount++;
        cnvRun++;
      end else if (cnvRun > 0) begin
        checkOutput("cnvWidth", cnvRun, 1);
        cnvRun = 0;
      end
      if (complete_o) begin
        if (completeRun == 0) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedComplete: actual data 0x%0h, required no completion", data_out_o);
          end else begin
            e = expQ.pop_front();
            checkOutput("dataOut", data_out_o, e.data);
            checkOutput("overrange", overrange_o, e.ovr);
          end
        end
        completeRun++;
      end else if (completeRun > 0) begin
        checkOutput("completeWidth", completeRun, 1);
        completeRun = 0;
      end
      if (timeout_err_o) checkOutput("timeoutExpected", timeout_err_o, expectTimeout);
    end
  end

  task automatic fillRandom(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 7) == 0) samp[i][k] = '1;
        else samp[i][k] = CH_WIDTH'($urandom);
      end
    end
  endtask

  task automatic startCycle(input int log2n, input bit withAbort);
    log2_n_i           = 4'(log2n);
    start_cycle_conv_i = 1'b1;
    @(negedge clk);
    if (withAbort) abort_i = 1'b1;
    @(negedge clk);
    abort_i            = 1'b0;
    start_cycle_conv_i = 1'b0;
    @(negedge clk);
    checkOutput("busyAfterStart", busy_o, 1);
  endtask

  task automatic waitCnv();
    int waited = 0;
    sample_adc_i = 1'b1;
    while (!cnv_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    sample_adc_i = 1'b0;
    checkOutput("cnvSeen", cnv_o, 1);
  endtask

  task automatic doConversion(input logic [FRAME_W-1:0] frame, input bit extraTick);
    frameQ.push_back(frame);
    waitCnv();
    for (int i = 0; i < CONV_WAIT; i++) begin
      @(negedge clk);
      if (extraTick && i == 20) sample_adc_i = 1'b1;
      if (i == 23) sample_adc_i = 1'b0;
    end
  endtask

  // One complete averaging cycle over samp[0 .. 2^n-1]; the reference
  // result is plain integer summing and dividing.
  task automatic applyStimulus(input int log2n, input bit poke, input bit withAbort);
    int                 nEff;
    int                 cnt;
    int                 cnvBefore;
    longint             sum;
    longint             avg;
    result_t            e;
    logic [FRAME_W-1:0] frame;
    nEff = (log2n > MAX_LOG2_N) ? MAX_LOG2_N : log2n;
    cnt  = 1 << nEff;
    e.data = '0;
    e.ovr  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = 0;
      for (int i = 0; i < cnt; i++) begin
        sum = sum + longint'(samp[i][k]);
        if (samp[i][k] == {CH_WIDTH{1'b1}}) e.ovr[k] = 1'b1;
      end
      avg = sum / (64'sd1 << nEff);
      e.data[k*OUT_WIDTH +: OUT_WIDTH] = avg[OUT_WIDTH-1:0];
    end
    expQ.push_back(e);
    cnvBefore = cnvCount;
    startCycle(log2n, withAbort);
    for (int i = 0; i < cnt; i++) begin
      frame = '0;
      for (int k = 0; k < NUM_CH; k++) frame[k*CH_WIDTH +: CH_WIDTH] = samp[i][k];
      doConversion(frame, poke && i == 0);
      if (poke && i == 0) begin
        log2_n_i           = 4'd0;
        start_cycle_conv_i = 1'b1;
        repeat (2) @(negedge clk);
        start_cycle_conv_i = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    for (int j = 0; j < 50 && busy_o; j++) @(negedge clk);
    checkOutput("busyIdle", busy_o, 0);
    checkOutput("cnvCount", cnvCount - cnvBefore, cnt);
    lastExpData = e.data;
  endtask

  initial begin
    logic [FRAME_W-1:0] frame;
    int                 cyc;
    rst_i              = 1'b1;
    start_cycle_conv_i = 1'b0;
    sample_adc_i       = 1'b0;
    log2_n_i           = 4'd0;
    abort_i            = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstCnv", cnv_o, 0);
    checkOutput("rstSck", sck_o, 0);
    checkOutput("rstComplete", complete_o, 0);
    checkOutput("rstTimeout", timeout_err_o, 0);
    checkOutput("rstData", data_out_o, 0);
    checkOutput("rstOvr", overrange_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] two-frame average, log2_n=1");
    samp[0][1] = 18'h00010; samp[0][0] = 18'h00020;
    samp[1][1] = 18'h00012; samp[1][0] = 18'h00022;
    applyStimulus(1, 0, 0);
    checkOutput("directCh1", data_out_o[OUT_WIDTH +: OUT_WIDTH], 24'h000011);
    checkOutput("directCh0", data_out_o[0 +: OUT_WIDTH], 24'h000021);
    checkOutput("directOvr", overrange_o, 2'b00);

    $display("[TB] full-scale sample in frame 3, log2_n=2");
    for (int i = 0; i < 4; i++) begin
      samp[i][0] = '0;
      samp[i][1] = '0;
    end
    samp[2][1] = '1;
    applyStimulus(2, 0, 0);
    checkOutput("fullScaleCh1", data_out_o[OUT_WIDTH +: OUT_WIDTH], 24'h00FFFF);
    checkOutput("fullScaleCh0", data_out_o[0 +: OUT_WIDTH], 24'h000000);
    checkOutput("fullScaleOvr", overrange_o, 2'b10);

    $display("[TB] passthrough with abort alongside start");
    samp[0][1] = 18'h15555; samp[0][0] = 18'h2ABCD;
    applyStimulus(0, 0, 1);
    checkOutput("passCh1", data_out_o[OUT_WIDTH +: OUT_WIDTH], 24'h015555);
    checkOutput("passCh0", data_out_o[0 +: OUT_WIDTH], 24'h02ABCD);

    $display("[TB] randomised cycles");
    for (int r = 0; r < 4; r++) begin
      fillRandom(8);
      applyStimulus($urandom_range(1, 3), (r == 1), 0);
    end

    $display("[TB] adc_busy stuck high");
    expectTimeout = 1;
    stuckBusy     = 1;
    startCycle(0, 0);
    waitCnv();
    cyc = 0;
    while (!timeout_err_o && cyc < BUSY_TIMEOUT + 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("timeoutLatency", cyc, BUSY_TIMEOUT);
    checkOutput("busyAfterTimeout", busy_o, 0);
    checkOutput("dataAfterTimeout", data_out_o, lastExpData);
    @(negedge clk);
    checkOutput("timeoutPulse", timeout_err_o, 0);
    expectTimeout = 0;
    stuckBusy     = 0;
    adc_busy_i    = 1'b0;
    repeat (5) @(negedge clk);
    fillRandom(2);
    applyStimulus(1, 0, 0);

    $display("[TB] abort while shifting");
    startCycle(1, 0);
    frameQ.push_back(FRAME_W'({$urandom, $urandom}));
    waitCnv();
    for (int j = 0; j < 40 && !sck_o; j++) @(negedge clk);
    checkOutput("sckActive", sck_o, 1);
    repeat (3) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("abortBusy", busy_o, 0);
    checkOutput("abortSck", sck_o, 0);
    checkOutput("abortCnv", cnv_o, 0);
    repeat (CONV_WAIT) @(negedge clk);
    checkOutput("abortData", data_out_o, lastExpData);
    fillRandom(4);
    applyStimulus(2, 0, 0);

    $display("[TB] reset in the middle of a cycle");
    startCycle(1, 0);
    frame = FRAME_W'({$urandom, $urandom});
    doConversion(frame, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("midRstData", data_out_o, 0);
    checkOutput("midRstOvr", overrange_o, 0);
    checkOutput("midRstBusy", busy_o, 0);
    lastExpData = '0;
    fillRandom(2);
    applyStimulus(1, 1, 0);

    $display("[TB] log2_n above the maximum");
    fillRandom(128);
    applyStimulus(15, 0, 0);

    repeat (5) @(negedge clk);
    checkOutput("pendingResults", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
